// File: rtl/commit_monitor_if.sv
// Final-state dump stream of the commit monitor.
// Master drives beats, slave returns ready.
interface commit_monitor_if #(
  parameter int XLEN = 32
);
  logic            dump_valid;
  logic            dump_ready;
  logic [5:0]      dump_idx;
  logic [XLEN-1:0] dump_data;
  logic            dump_last;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    input  dump_last,
    output dump_ready
  );
endinterface

// File: rtl/commit_monitor.sv
// Retire-stream monitor: counters, shadow regfile,
// halt detect, drain, and final-state dump.
module commit_monitor #(
  parameter int          XLEN         = 32,
  parameter int          CNT_W        = 32,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] HALT_INSTR   = 32'h00100073
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic [31:0]      wb_instr,
  input  logic             wb_rd_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_rd_data,
  output logic             halt_req,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count,
  commit_monitor_if.master dump,
  output logic             done
);

  localparam int DW =
    (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DUMP,
    S_DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            halt_hit;
  logic            xfer;
  logic            run;
  logic [DW-1:0]   drain_q;
  logic [5:0]      idx_q;
  logic [XLEN-1:0] halt_pc_q;
  logic [XLEN-1:0] shadow [32];
  logic [4:0]      rsel;

  assign run = (state_q == S_RUN);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RUN;
    else      state_q <= state_d;
  end

  // Next-state decode plus halt/transfer strobes.
  always_comb begin
    state_d  = state_q;
    halt_hit = 1'b0;
    xfer     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (wb_valid && wb_instr == HALT_INSTR) begin
          halt_hit = 1'b1;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DUMP;
      end
      S_DUMP: begin
        if (dump.dump_ready) begin
          xfer = 1'b1;
          if (idx_q == 6'd32) state_d = S_DONE;
        end
      end
      S_DONE: ;
      default: state_d = S_RUN;
    endcase
  end

  // Counters advance only while running; they freeze at halt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else if (run) begin
      cycle_count <= cycle_count + CNT_W'(1);
      if (wb_valid)
        instret_count <= instret_count + CNT_W'(1);
    end
  end

  // Shadow regfile; x0 is never written so it reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
    end else if (run && wb_valid && wb_rd_we
                 && wb_rd != 5'd0) begin
      shadow[wb_rd] <= wb_rd_data;
    end
  end

  // Halt PC capture, drain countdown and dump index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_pc_q <= '0;
      drain_q   <= '0;
      idx_q     <= '0;
    end else begin
      if (halt_hit) begin
        halt_pc_q <= wb_pc;
        drain_q   <= DW'(DRAIN_CYCLES);
      end else if (state_q == S_DRAIN
                   && drain_q != '0) begin
        drain_q <= drain_q - DW'(1);
      end
      if (xfer && idx_q != 6'd32)
        idx_q <= idx_q + 6'd1;
    end
  end

  // idx 1..32 maps to x0..x31; idx 32 wraps to 31.
  assign rsel = idx_q[4:0] - 5'd1;

  assign halted          = !run;
  assign halt_req        = !run;
  assign done            = (state_q == S_DONE);
  assign dump.dump_valid = (state_q == S_DUMP);
  assign dump.dump_idx   = idx_q;
  assign dump.dump_last  = (state_q == S_DUMP)
                           && (idx_q == 6'd32);
  assign dump.dump_data  = (idx_q == 6'd0) ? halt_pc_q
                                           : shadow[rsel];

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor: default instance
// plus a 4-bit-counter, zero-drain instance.
module tb_commit_monitor;

  localparam logic [31:0] HALT = 32'h00100073;

  logic        clk;
  logic        rst;
  logic        rstb;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_instr;
  logic        wb_rd_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rd_data;

  logic        hreq_a, hlt_a, done_a;
  logic [31:0] cyc_a, ins_a;
  logic        hreq_b, hlt_b, done_b;
  logic [3:0]  cyc_b, ins_b;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] expd [33];

  commit_monitor_if #(.XLEN(32)) ifa ();
  commit_monitor_if #(.XLEN(32)) ifb ();

  commit_monitor u_a (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_instr(wb_instr), .wb_rd_we(wb_rd_we),
    .wb_rd(wb_rd), .wb_rd_data(wb_rd_data),
    .halt_req(hreq_a), .halted(hlt_a),
    .cycle_count(cyc_a), .instret_count(ins_a),
    .dump(ifa.master), .done(done_a)
  );

  commit_monitor #(
    .CNT_W(4), .DRAIN_CYCLES(0)
  ) u_b (
    .clk(clk), .rst(rstb),
    .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_instr(wb_instr), .wb_rd_we(wb_rd_we),
    .wb_rd(wb_rd), .wb_rd_data(wb_rd_data),
    .halt_req(hreq_b), .halted(hlt_b),
    .cycle_count(cyc_b), .instret_count(ins_b),
    .dump(ifb.master), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc,
                        input logic [31:0] ins,
                        input logic we,
                        input logic [4:0] rd,
                        input logic [31:0] d);
    wb_valid   = 1'b1;
    wb_pc      = pc;
    wb_instr   = ins;
    wb_rd_we   = we;
    wb_rd      = rd;
    wb_rd_data = d;
    tick();
    wb_valid   = 1'b0;
    wb_rd_we   = 1'b0;
  endtask

  task automatic chk_zero_a(input string tag);
    check({tag, "_hreq"}, hreq_a, 0);
    check({tag, "_hlt"}, hlt_a, 0);
    check({tag, "_cyc"}, cyc_a, 0);
    check({tag, "_ins"}, ins_a, 0);
    check({tag, "_valid"}, ifa.dump_valid, 0);
    check({tag, "_idx"}, ifa.dump_idx, 0);
    check({tag, "_data"}, ifa.dump_data, 0);
    check({tag, "_last"}, ifa.dump_last, 0);
    check({tag, "_done"}, done_a, 0);
  endtask

  // Consume one dump from DUT A, checking each beat
  // against expd; alt toggles ready every cycle.
  task automatic run_dump(input bit alt,
                          output int beats);
    beats = 0;
    for (int c = 0; c < 200 && !done_a; c++) begin
      ifa.dump_ready = alt ? (c % 2 == 0) : 1'b1;
      if (ifa.dump_valid) begin
        check("beat_idx", ifa.dump_idx, beats);
        check("beat_data", ifa.dump_data,
              expd[beats]);
        check("beat_last", ifa.dump_last,
              beats == 32);
        if (ifa.dump_ready) beats++;
      end
      tick();
    end
    ifa.dump_ready = 1'b0;
  endtask

  initial begin
    int n;
    int beats;
    rst = 1'b0;
    rstb = 1'b0;
    wb_valid = 1'b0;
    wb_pc = '0;
    wb_instr = '0;
    wb_rd_we = 1'b0;
    wb_rd = '0;
    wb_rd_data = '0;
    ifa.dump_ready = 1'b0;
    ifb.dump_ready = 1'b0;

    tick();
    tick();
    chk_zero_a("rst");

    rst = 1'b1;
    repeat (5) tick();
    check("idle_cyc", cyc_a, 5);
    check("idle_ins", ins_a, 0);
    check("idle_hlt", hlt_a, 0);

    retire(32'h0, 32'h00500093, 1'b1, 5'd1, 32'd5);
    retire(32'h4, 32'h0000_0013, 1'b1, 5'd0,
           32'hDEAD);
    retire(32'h8, HALT, 1'b0, 5'd0, 32'd0);
    check("halt_ins", ins_a, 3);
    check("halt_cyc", cyc_a, 8);
    check("halt_req", hreq_a, 1);
    check("halt_hlt", hlt_a, 1);
    check("halt_nov", ifa.dump_valid, 0);

    retire(32'hC, 32'h07700193, 1'b1, 5'd3,
           32'h77);
    retire(32'h10, HALT, 1'b0, 5'd0, 32'd0);
    n = 2;
    while (!ifa.dump_valid && n < 50) begin
      tick();
      n++;
    end
    check("drain_len", n, 5);
    check("drain_ins", ins_a, 3);
    check("drain_cyc", cyc_a, 8);

    for (int i = 0; i < 33; i++) expd[i] = '0;
    expd[0] = 32'h8;
    expd[2] = 32'd5;
    run_dump(1'b1, beats);
    check("dump_beats", beats, 33);
    check("dump_done", done_a, 1);
    check("done_nov", ifa.dump_valid, 0);
    check("done_hreq", hreq_a, 1);

    ifa.dump_ready = 1'b1;
    retire(32'h20, HALT, 1'b1, 5'd4, 32'h9);
    tick();
    check("post_nov", ifa.dump_valid, 0);
    check("post_done", done_a, 1);
    check("post_ins", ins_a, 3);
    ifa.dump_ready = 1'b0;

    rst = 1'b0;
    #1;
    chk_zero_a("rst2");
    tick();
    rst = 1'b1;
    retire(32'h20, 32'h0, 1'b1, 5'd2, 32'h1234);
    retire(32'h24, HALT, 1'b0, 5'd0, 32'd0);
    ifa.dump_ready = 1'b1;
    n = 0;
    while (!(ifa.dump_valid && ifa.dump_idx == 6'd10)
           && n < 100) begin
      tick();
      n++;
    end
    check("mid_reach", ifa.dump_idx, 10);
    rst = 1'b0;
    #1;
    chk_zero_a("mid_rst");
    tick();
    rst = 1'b1;

    retire(32'h100, HALT, 1'b0, 5'd0, 32'd0);
    check("rst_cyc", cyc_a, 1);
    check("rst_ins", ins_a, 1);
    n = 0;
    while (!ifa.dump_valid && n < 50) begin
      tick();
      n++;
    end
    check("rst_drain", n, 5);
    for (int i = 0; i < 33; i++) expd[i] = '0;
    expd[0] = 32'h100;
    run_dump(1'b0, beats);
    check("rst_beats", beats, 33);

    rstb = 1'b1;
    repeat (17) tick();
    check("wrap_cyc", cyc_b, 1);
    check("wrap_ins", ins_b, 0);
    retire(32'h50, HALT, 1'b0, 5'd0, 32'd0);
    check("b_cyc", cyc_b, 2);
    check("b_ins", ins_b, 1);
    check("b_hreq", hreq_b, 1);
    check("b_nov", ifb.dump_valid, 0);
    tick();
    check("b_valid", ifb.dump_valid, 1);
    check("b_idx", ifb.dump_idx, 0);
    check("b_data", ifb.dump_data, 32'h50);
    ifb.dump_ready = 1'b1;
    n = 0;
    while (!done_b && n < 100) begin
      tick();
      n++;
    end
    check("b_beats", n, 33);
    check("b_cyc_hold", cyc_b, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_monitor.md
Name: commit_monitor

Overview:
- Sits directly downstream of the pipelined RV32I core's writeback stage and consumes its retire stream.
- Tracks cycle and retired-instruction counts and keeps a shadow architectural register file.
- Detects the halt instruction (EBREAK) at retire, requests the core to stop, and drains for a fixed number of cycles.
- Then streams out the final state (halt PC plus x0..x31) over a valid/ready interface for benches and debug logging.

Parameters:
XLEN, 32, datapath and register width
CNT_W, 32, width of cycle and instret counters (wrap modulo 2^CNT_W)
DRAIN_CYCLES, 4, cycles spent in DRAIN after halt retire before dumping (0 allowed)
HALT_INSTR, 32'h00100073, encoding that triggers halt when retired

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
wb_valid  input  1  one instruction retires this cycle
wb_pc  input  XLEN  PC of retiring instruction
wb_instr  input  32  encoding of retiring instruction
wb_rd_we  input  1  retiring instruction writes rd
wb_rd  input  5  destination register index
wb_rd_data  input  XLEN  value written to rd
halt_req  output  1  request core to stop fetch/retire; sticky until reset
halted  output  1  high whenever state is not RUN
cycle_count  output  CNT_W  cycles counted in RUN
instret_count  output  CNT_W  instructions retired, halt instruction included
dump_valid  output  1  dump beat available
dump_ready  input  1  consumer accepts beat
dump_idx  output  6  0 = halt PC, k = x(k-1) for k = 1..32
dump_data  output  XLEN  beat payload
dump_last  output  1  high with dump_valid when dump_idx == 32
done  output  1  dump complete; sticky until reset

Behaviour:
- Reset (rst low, async): state RUN; all outputs 0; shadow regs, halt_pc, drain counter and dump index all 0. Reset mid-operation (any state) aborts fully; no resumption.
- States: RUN -> DRAIN -> DUMP -> DONE. Only reset leaves DONE.
- RUN, every clock:
  - cycle_count += 1.
  - If wb_valid: instret_count += 1.
  - If wb_valid & wb_rd_we & wb_rd != 0: shadow[wb_rd] <= wb_rd_data. Writes to x0 are dropped.
  - Counter updates are registered, so a counter shows its new value in the cycle after the event.
- Halt: wb_valid & wb_instr == HALT_INSTR in RUN.
  - That cycle still increments cycle_count and instret_count and applies any rd write.
  - Capture halt_pc <= wb_pc and load drain counter with DRAIN_CYCLES.
  - Next cycle: state DRAIN, halt_req = 1, halted = 1.
- After halt (DRAIN/DUMP/DONE):
  - cycle_count and instret_count freeze.
  - wb_* inputs are ignored entirely: no shadow writes, no counting, no re-trigger on a second HALT_INSTR.
- DRAIN:
  - Counter nonzero: decrement.
  - Counter zero: go to DUMP next cycle. With DRAIN_CYCLES = 0, DRAIN lasts exactly one cycle.
- DUMP:
  - dump_valid = 1 with dump_idx starting at 0.
  - dump_data = halt_pc for idx 0; shadow[idx-1] for idx 1..32. idx 1 (x0) is always 0.
  - Beat transfers when dump_valid & dump_ready. idx increments by 1 per transfer.
  - While dump_ready is low, dump_idx, dump_data and dump_last hold stable.
  - dump_last = (dump_idx == 32).
  - Transfer with dump_last: next cycle state DONE, dump_valid = 0, done = 1.
  - Exactly 33 beats per dump.
- DONE: done = 1, halted = 1, halt_req = 1, dump_valid = 0; counters hold.
- Counters wrap modulo 2^CNT_W; no saturation, no flag.
- All outputs are registered or decoded from registered state; no combinational path from wb_* or dump_ready to any output.

Test Plan:
- Reset/idle: hold rst = 0 for 2 cycles -> all outputs 0. Release, 5 cycles with wb_valid = 0 -> cycle_count = 5, instret_count = 0, halted = 0.
- Basic run: retire x1 <= 5 at pc 0x0, x0 <= 0xDEAD at pc 0x4, then HALT_INSTR at pc 0x8 -> instret_count = 3, halt_req high next cycle, and DUMP starts DRAIN_CYCLES + 1 cycles after halt_req rises. With dump_ready = 1, beats are idx 0 = 0x8, idx 1 = 0, idx 2 = 5, idx 3..32 = 0, dump_last only on idx 32, then done = 1.
- Backpressure: dump_ready alternates 1,0 -> payload stable while low; exactly 33 transfers; indices strictly 0..32 with no skips or repeats.
- Post-halt traffic: during DRAIN, drive wb_valid with wb_rd_we = 1, wb_rd = 3, data 0x77, plus a second HALT_INSTR -> instret_count unchanged, idx 4 dumps 0, only one dump occurs.
- Reset mid-dump: assert rst at dump_idx = 10 -> all outputs 0 immediately (asynchronously). After release: state RUN, shadow regs cleared, counters restart from 0.
- Wrap/zero drain: CNT_W = 4, DRAIN_CYCLES = 0, run 17 cycles -> cycle_count = 1. Halt -> DUMP begins 2 cycles after halt retire.
